// File: rtl/rf_multiport_sb_pkg.sv
// Shared defaults for the multi-port register file and its scoreboard.
// WORD and REG_LOG feed the WIDTH / NREG parameter defaults of every module in this slice.
package rf_multiport_sb_pkg;

    localparam int WORD     = 32;
    localparam int REG_LOG  = 5;
    localparam int NREG_DEF = 1 << REG_LOG;
    localparam int NRD_DEF  = 2;
    localparam int NWR_DEF  = 2;

endpackage

// File: rtl/rf_multiport_sb_if.sv
// Operand/writeback/issue bundle between the ID stage and the register file.
// Ports are flattened: port p occupies [p*AW +: AW] / [p*WIDTH +: WIDTH].
interface rf_multiport_sb_if
    import rf_multiport_sb_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int NREG  = NREG_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic [NWR-1:0]       we;
    logic [NWR*AW-1:0]    waddr;
    logic [NWR*WIDTH-1:0] wdata;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*WIDTH-1:0] rdata;
    logic [NRD-1:0]       rbusy;
    logic                 issue_en;
    logic [AW-1:0]        issue_rd;
    logic [CW-1:0]        busy_cnt;

    modport master (
        output we, waddr, wdata, raddr, issue_en, issue_rd,
        input  rdata, rbusy, busy_cnt
    );

    modport slave (
        input  we, waddr, wdata, raddr, issue_en, issue_rd,
        output rdata, rbusy, busy_cnt
    );

endinterface

// File: rtl/rf_multiport_sb_scoreboard.sv
// Busy scoreboard: one bit per register, set on issue, cleared on writeback (set wins),
// plus a registered popcount of the busy vector.
module rf_scoreboard #(
    parameter int NREG = 32,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG),
    parameter int CW   = $clog2(NREG + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic [NWR-1:0]    clr_en,
    input  logic [NWR*AW-1:0] clr_addr,
    output logic [NREG-1:0]   busy,
    output logic [CW-1:0]     busy_cnt
);

    logic [NREG-1:0] busy_next;
    logic [CW-1:0]   cnt_next;

    // NOTE: every always_comb output gets a default first; a path that skips an assignment infers a latch.
    always_comb begin
        busy_next = busy;
        for (int p = 0; p < NWR; p++) begin
            if (clr_en[p] && clr_addr[p*AW +: AW] != '0)
                busy_next[clr_addr[p*AW +: AW]] = 1'b0;
        end
        // A new producer issued in the same cycle as a writeback stays outstanding.
        if (set_en && set_addr != '0)
            busy_next[set_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREG; i++)
            cnt_next = cnt_next + CW'(busy_next[i]);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/rf_multiport_sb.sv
// Multi-port integer register file with busy scoreboard; x0 reads zero and is never busy.
// Define RF_BYPASS_EN to forward same-cycle writeback data (and clear rbusy) onto the read ports.
module rf_multiport_sb
    import rf_multiport_sb_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int NREG  = NREG_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int NWR   = NWR_DEF
) (
    input logic              clk,
    input logic              rst,
    rf_multiport_sb_if.slave bus
);

    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic [WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]  busy;

    rf_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW),
        .CW   (CW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (bus.issue_en),
        .set_addr (bus.issue_rd),
        .clr_en   (bus.we),
        .clr_addr (bus.waddr),
        .busy     (busy),
        .busy_cnt (bus.busy_cnt)
    );

    // NOTE: the array is reset because reads must return zero after rst; this keeps it in flops, not RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            // Ascending port order: the last update to an address wins, giving the highest port priority.
            for (int p = 0; p < NWR; p++) begin
                if (bus.we[p] && bus.waddr[p*AW +: AW] != '0)
                    regs[bus.waddr[p*AW +: AW]] <= bus.wdata[p*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        bus.rbusy = '0;
        if (!rst) begin
            for (int r = 0; r < NRD; r++) begin
                if (bus.raddr[r*AW +: AW] != '0) begin
                    bus.rdata[r*WIDTH +: WIDTH] = regs[bus.raddr[r*AW +: AW]];
                    bus.rbusy[r]                = busy[bus.raddr[r*AW +: AW]];
`ifdef RF_BYPASS_EN
                    for (int p = 0; p < NWR; p++) begin
                        if (bus.we[p] && bus.waddr[p*AW +: AW] == bus.raddr[r*AW +: AW]) begin
                            bus.rdata[r*WIDTH +: WIDTH] = bus.wdata[p*WIDTH +: WIDTH];
                            bus.rbusy[r]                = 1'b0;
                        end
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed bench for rf_multiport_sb: table of single-edge vectors plus hand sequences
// for bypass, busy_cnt saturation and asynchronous reset.
module tb_rf_multiport_sb;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rf_multiport_sb_if bus ();

    rf_multiport_sb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        ie;
        logic [4:0]  ird;
        logic [4:0]  ra0, ra1;
        logic [31:0] exp_rd0, exp_rd1;
        logic        exp_rb0, exp_rb1;
        logic [5:0]  exp_cnt;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1, input logic ie, input logic [4:0] ird,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [31:0] exp_rd0, input logic exp_rb0,
        input logic [31:0] exp_rd1, input logic exp_rb1, input logic [5:0] exp_cnt);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ie = ie; v.ird = ird; v.ra0 = ra0; v.ra1 = ra1;
        v.exp_rd0 = exp_rd0; v.exp_rb0 = exp_rb0;
        v.exp_rd1 = exp_rd1; v.exp_rb1 = exp_rb1; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic idle();
        bus.we       = '0;
        bus.issue_en = 1'b0;
        bus.issue_rd = '0;
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic ie, input logic [4:0] ird);
        bus.we       = we;
        bus.waddr    = {wa1, wa0};
        bus.wdata    = {wd1, wd0};
        bus.issue_en = ie;
        bus.issue_rd = ird;
    endtask

    // Inputs are dropped 1 time unit after the edge, so checks see committed state only.
    task automatic edge_then_idle();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic set_read(input logic [4:0] ra0, input logic [4:0] ra1);
        bus.raddr = {ra1, ra0};
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        bus.raddr = '0;
        bus.waddr = '0;
        bus.wdata = '0;
        idle();

        //            we     wa0  wd0           wa1  wd1        ie    ird  ra0  ra1  rd0           rb0   rd1     rb1   cnt
        vecs[0] = mk(2'b11, 5'd3, 32'h11,       5'd3, 32'h22,   1'b0, 5'd0, 5'd3, 5'd0, 32'h22,     1'b0, 32'h0,  1'b0, 6'd0);
        vecs[1] = mk(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,    1'b1, 5'd0, 5'd0, 5'd3, 32'h0,      1'b0, 32'h22, 1'b0, 6'd0);
        vecs[2] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 5'd0, 32'h0,      1'b1, 32'h0,  1'b0, 6'd1);
        vecs[3] = mk(2'b01, 5'd7, 32'h5,        5'd0, 32'h0,    1'b1, 5'd7, 5'd7, 5'd3, 32'h5,      1'b1, 32'h22, 1'b0, 6'd1);
        vecs[4] = mk(2'b10, 5'd0, 32'h0,        5'd7, 32'h5,    1'b0, 5'd0, 5'd7, 5'd0, 32'h5,      1'b0, 32'h0,  1'b0, 6'd0);
        vecs[5] = mk(2'b11, 5'd4, 32'h44,       5'd4, 32'h55,   1'b1, 5'd4, 5'd4, 5'd7, 32'h55,     1'b1, 32'h5,  1'b0, 6'd1);
        vecs[6] = mk(2'b11, 5'd5, 32'h77,       5'd4, 32'h66,   1'b0, 5'd0, 5'd4, 5'd5, 32'h66,     1'b0, 32'h77, 1'b0, 6'd0);
        vecs[7] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    1'b1, 5'd6, 5'd6, 5'd0, 32'h0,      1'b1, 32'h0,  1'b0, 6'd1);
        vecs[8] = mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,    1'b1, 5'd6, 5'd6, 5'd5, 32'h0,      1'b1, 32'h77, 1'b0, 6'd1);
        vecs[9] = mk(2'b01, 5'd6, 32'h99,       5'd0, 32'h0,    1'b0, 5'd0, 5'd6, 5'd4, 32'h99,     1'b0, 32'h66, 1'b0, 6'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_read(5'd3, 5'd31);
        check("reset_rdata0", bus.rdata[31:0], 32'h0);
        check("reset_rdata1", bus.rdata[63:32], 32'h0);
        check("reset_rbusy", {30'd0, bus.rbusy}, 32'h0);
        check("reset_cnt", {26'd0, bus.busy_cnt}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            bus.raddr = {vecs[i].ra1, vecs[i].ra0};
            drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1, vecs[i].ie, vecs[i].ird);
            edge_then_idle();
            check($sformatf("v%0d_rdata0", i), bus.rdata[31:0], vecs[i].exp_rd0);
            check($sformatf("v%0d_rbusy0", i), {31'd0, bus.rbusy[0]}, {31'd0, vecs[i].exp_rb0});
            check($sformatf("v%0d_rdata1", i), bus.rdata[63:32], vecs[i].exp_rd1);
            check($sformatf("v%0d_rbusy1", i), {31'd0, bus.rbusy[1]}, {31'd0, vecs[i].exp_rb1});
            check($sformatf("v%0d_cnt", i), {26'd0, bus.busy_cnt}, {26'd0, vecs[i].exp_cnt});
        end

        // Bypass: x9 holds 0xA and is busy, then port 1 writes 0xB.
        set_read(5'd9, 5'd0);
        drive(2'b01, 5'd9, 32'hA, 5'd0, 32'h0, 1'b1, 5'd9);
        edge_then_idle();
        check("byp_setup_rdata", bus.rdata[31:0], 32'hA);
        check("byp_setup_rbusy", {31'd0, bus.rbusy[0]}, 32'h1);
        drive(2'b10, 5'd0, 32'h0, 5'd9, 32'hB, 1'b0, 5'd0);
        #1;
`ifdef RF_BYPASS_EN
        check("byp_same_cycle_rdata", bus.rdata[31:0], 32'hB);
        check("byp_same_cycle_rbusy", {31'd0, bus.rbusy[0]}, 32'h0);
`else
        check("byp_same_cycle_rdata", bus.rdata[31:0], 32'hA);
        check("byp_same_cycle_rbusy", {31'd0, bus.rbusy[0]}, 32'h1);
`endif
        edge_then_idle();
        check("byp_after_rdata", bus.rdata[31:0], 32'hB);
        check("byp_after_rbusy", {31'd0, bus.rbusy[0]}, 32'h0);
        check("byp_after_cnt", {26'd0, bus.busy_cnt}, 32'h0);

        // Saturation: issue x1..x31 on consecutive cycles.
        for (int r = 1; r < 32; r++) begin
            bus.issue_en = 1'b1;
            bus.issue_rd = 5'(r);
            @(posedge clk);
            #1;
        end
        idle();
        set_read(5'd31, 5'd1);
        check("sat_cnt", {26'd0, bus.busy_cnt}, 32'd31);
        check("sat_rbusy", {30'd0, bus.rbusy}, 32'h3);
        set_read(5'd17, 5'd1);
        drive(2'b01, 5'd17, 32'h1717, 5'd0, 32'h0, 1'b0, 5'd0);
        edge_then_idle();
        check("sat_clear_cnt", {26'd0, bus.busy_cnt}, 32'd30);
        check("sat_clear_rdata", bus.rdata[31:0], 32'h1717);
        check("sat_clear_rbusy", {30'd0, bus.rbusy}, 32'h2);

        // Async reset pulsed mid-cycle clears data, busy and count immediately.
        set_read(5'd5, 5'd17);
        drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1, 5'd5);
        edge_then_idle();
        check("rst_pre_rdata", bus.rdata[31:0], 32'hDEADBEEF);
        check("rst_pre_rbusy", {31'd0, bus.rbusy[0]}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_rdata", bus.rdata[31:0], 32'h0);
        check("rst_mid_rbusy", {30'd0, bus.rbusy}, 32'h0);
        check("rst_mid_cnt", {26'd0, bus.busy_cnt}, 32'h0);
        #1;
        rst = 1'b0;
        edge_then_idle();
        check("rst_post_rdata", bus.rdata[63:32], 32'h0);
        check("rst_post_cnt", {26'd0, bus.busy_cnt}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
